// File: rtl/settings_pkg.sv
// rtl/settings_pkg.sv - shared data-path sizing for the pulse-processing chain
package settings_pkg;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/trap_filter_ctrl_pkg.sv
// rtl/trap_filter_ctrl_pkg.sv - trapezoid filter controller constants and state type
package trap_filter_ctrl_pkg;
  localparam int FILTER_LATENCY = 4;
  localparam int CFG_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_e;
endpackage

// File: rtl/trap_filter_ctrl_if.sv
// rtl/trap_filter_ctrl_if.sv - sample in / result out streams of the filter controller
interface trap_filter_ctrl_if #(parameter int DW = settings_pkg::SIZE_FILTER_DATA);
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 m_valid;
  logic signed [DW-1:0] m_data;
  logic                 m_last;

  modport slave  (input s_valid, s_data, output s_ready, m_valid, m_data, m_last);
  modport master (output s_valid, s_data, input s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/trap_filter_ctrl_filt_tag_pipe.sv
// rtl/trap_filter_ctrl_filt_tag_pipe.sv - tag delay line matching the external filter latency
module filt_tag_pipe #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic tag_in,
  output logic tag_out
);
  logic [LAT-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_in;
    for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
    if (clr) pipe_d = '0;
  end

  always_ff @(posedge clk) pipe_q <= pipe_d;

  assign tag_out = pipe_q[LAT-1];
endmodule

// File: rtl/trap_filter_ctrl.sv
// rtl/trap_filter_ctrl.sv - run/flush/drain sequencing around an external shaping filter
module trap_filter_ctrl
  import trap_filter_ctrl_pkg::*;
#(
  parameter int DW  = settings_pkg::SIZE_FILTER_DATA,
  parameter int CW  = CFG_W,
  parameter int LAT = FILTER_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CW-1:0]        cfg_k,
  input  logic [CW-1:0]        cfg_l,
  input  logic                 stop,
  trap_filter_ctrl_if.slave    bus,
  output logic                 flt_clr,
  output logic signed [DW-1:0] flt_data,
  input  logic signed [DW-1:0] flt_result,
  output logic                 busy
);
  localparam int DCW = $clog2(LAT + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(LAT);

  state_e         state_q, state_d;
  logic [CW-1:0]  kq_q, kq_d, lq_q, lq_d;
  logic [CW:0]    n_q, n_d, fcnt_q, fcnt_d, warm;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           stop_pend_q, stop_pend_d;

  logic                 s_ready_c, flt_clr_c, m_last_c, m_valid_c, busy_c;
  logic signed [DW-1:0] flt_data_c, m_data_c;
  logic                 accept, tag_in, tag_out;

  assign warm = {1'b0, kq_q} + {1'b0, lq_q};

  always_comb begin
    state_d     = state_q;
    kq_d        = kq_q;
    lq_d        = lq_q;
    n_d         = n_q;
    fcnt_d      = fcnt_q;
    dcnt_d      = dcnt_q;
    stop_pend_d = stop_pend_q;
    s_ready_c   = 1'b0;
    flt_clr_c   = 1'b0;
    flt_data_c  = '0;
    m_last_c    = 1'b0;
    busy_c      = (state_q != ST_IDLE);
    accept      = 1'b0;
    tag_in      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          kq_d    = (cfg_k == '0) ? CW'(1) : cfg_k;
          lq_d    = (cfg_l == '0) ? CW'(1) : cfg_l;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        flt_clr_c   = 1'b1;
        n_d         = '0;
        fcnt_d      = '0;
        dcnt_d      = '0;
        stop_pend_d = stop;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        // A stop caught during CLEAR closes the run before any sample is taken.
        s_ready_c = ~stop_pend_q;
        if (s_ready_c && bus.s_valid) begin
          flt_data_c = bus.s_data;
          accept     = 1'b1;
        end
        if (stop || stop_pend_q) begin
          stop_pend_d = 1'b0;
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        accept = 1'b1;
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == warm - 1'b1) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (dcnt_q == DRAIN_LAST) begin
          m_last_c = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Results before the window has filled with real samples are not valid.
    if (accept) begin
      tag_in = (n_q >= warm);
      if (n_q < warm) n_d = n_q + 1'b1;
    end

    m_valid_c = tag_out;
    m_data_c  = tag_out ? flt_result : '0;

    if (reset) begin
      s_ready_c  = 1'b0;
      flt_clr_c  = 1'b1;
      flt_data_c = '0;
      m_valid_c  = 1'b0;
      m_data_c   = '0;
      m_last_c   = 1'b0;
      busy_c     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      kq_q        <= '0;
      lq_q        <= '0;
      n_q         <= '0;
      fcnt_q      <= '0;
      dcnt_q      <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kq_q        <= kq_d;
      lq_q        <= lq_d;
      n_q         <= n_d;
      fcnt_q      <= fcnt_d;
      dcnt_q      <= dcnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  filt_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk     (clk),
    .clr     (reset || (state_q == ST_CLEAR)),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_c;
  assign bus.m_data  = m_data_c;
  assign bus.m_last  = m_last_c;
  assign flt_clr     = flt_clr_c;
  assign flt_data    = flt_data_c;
  assign busy        = busy_c;
endmodule
